// File: rtl/relu_maxpool2x2_if.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool2x2_if
// Brief    : Pixel-stream bundle for the 2x2 max-pool / ReLU stage.
// Revision : 1.0
// ============================================================================
interface relu_maxpool2x2_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_invalid;
    logic [DATA_W-1:0] out_data;
    logic              out_invalid;
    logic              finish;

    // master is the producer of input pixels and consumer of pooled output
    modport master (
        output in_data,
        output in_invalid,
        input  out_data,
        input  out_invalid,
        input  finish
    );

    modport slave (
        input  in_data,
        input  in_invalid,
        output out_data,
        output out_invalid,
        output finish
    );
endinterface
`default_nettype wire

// File: rtl/relu_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool2x2
// Brief    : Streaming 2x2/stride-2 signed max-pool followed by ReLU.
// Revision : 1.0
// ============================================================================
module relu_maxpool2x2 #(
    parameter int IN_W   = 24,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    relu_maxpool2x2_if.slave   bus
);
    localparam int HALF = IN_W / 2;
    localparam int CW   = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] c_last = CW'(IN_W - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [CW-1:0]            r_col;
    logic [CW-1:0]            r_row;
    logic signed [DATA_W-1:0] r_h;
    logic signed [DATA_W-1:0] r_lb [HALF];
    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_invalid;
    logic                     r_finish;

    logic                     w_accept;
    logic [LBW-1:0]           w_idx;
    logic signed [DATA_W-1:0] w_px;
    logic signed [DATA_W-1:0] w_lb_rd;
    logic signed [DATA_W-1:0] w_m;
    logic signed [DATA_W-1:0] w_p;
    logic [DATA_W-1:0]        w_relu;
    logic                     w_last;

    // reset wins over a coincident pixel, and a finished frame ignores input
    assign w_accept = reset && !bus.in_invalid && !r_finish;
    assign w_idx    = LBW'(r_col >> 1);
    assign w_px     = bus.in_data;
    assign w_lb_rd  = r_lb[w_idx];
    assign w_m      = (w_px > r_h) ? w_px : r_h;
    assign w_p      = (w_lb_rd > w_m) ? w_lb_rd : w_m;
    assign w_relu   = w_p[DATA_W-1] ? '0 : w_p;
    assign w_last   = (r_row == c_last) && (r_col == c_last);

    // Line buffer has no reset: each entry is rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (w_accept && r_col[0] && !r_row[0]) begin
            r_lb[w_idx] <= w_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col         <= '0;
            r_row         <= '0;
            r_h           <= '0;
            r_out_data    <= '0;
            r_out_invalid <= 1'b1;
            r_finish      <= 1'b0;
        end else begin
            r_out_invalid <= 1'b1;
            if (w_accept) begin
                if (r_col == c_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last) ? '0 : r_row + c_one;
                end else begin
                    r_col <= r_col + c_one;
                end

                if (!r_col[0]) begin
                    r_h <= w_px;
                end else if (r_row[0]) begin
                    r_out_data    <= w_relu;
                    r_out_invalid <= 1'b0;
                    if (w_last) begin
                        r_finish <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_invalid = r_out_invalid;
    assign bus.finish      = r_finish;
endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool2x2
// Brief    : Directed self-checking bench for relu_maxpool2x2.
// Revision : 1.0
// ============================================================================
module tb_relu_maxpool2x2;
    localparam int IN_W   = 24;
    localparam int DATA_W = 32;
    localparam int NPIX   = IN_W * IN_W;
    localparam int NOUT   = (IN_W / 2) * (IN_W / 2);

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [DATA_W-1:0] last_exp;

    relu_maxpool2x2_if #(.DATA_W(DATA_W)) bus ();

    relu_maxpool2x2 #(
        .IN_W   (IN_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reset held for two edges with a valid pixel present, which must be dropped
    task automatic do_reset();
        reset          = 1'b0;
        bus.in_invalid = 1'b0;
        bus.in_data    = 32'd999;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_invalid", 32'(bus.out_invalid), 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_finish", 32'(bus.finish), 32'd0);
        last_exp = '0;
        reset    = 1'b1;
    endtask

    // full ramp frame; neg selects -1..-N, gaps inserts an idle cycle after each pixel
    task automatic run_ramp(input bit neg, input bit gaps);
        int n_out;
        int r;
        int c;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] exp_d;
        logic              is_out;
        n_out = 0;
        for (int i = 0; i < NPIX; i++) begin
            r   = i / IN_W;
            c   = i % IN_W;
            val = neg ? 32'(-(i + 1)) : 32'(i + 1);
            bus.in_data    = val;
            bus.in_invalid = 1'b0;
            @(posedge clk);
            #1;
            is_out = (r % 2 == 1) && (c % 2 == 1);
            if (is_out) last_exp = neg ? 32'd0 : val;
            exp_d = last_exp;
            chk("px_out_invalid", 32'(bus.out_invalid), is_out ? 32'd0 : 32'd1);
            chk("px_out_data", bus.out_data, exp_d);
            chk("px_finish", 32'(bus.finish), (i == NPIX - 1) ? 32'd1 : 32'd0);
            if (!bus.out_invalid) n_out++;
            if (gaps) begin
                bus.in_invalid = 1'b1;
                bus.in_data    = $urandom;
                @(posedge clk);
                #1;
                chk("gap_out_invalid", 32'(bus.out_invalid), 32'd1);
                chk("gap_out_data", bus.out_data, exp_d);
                chk("gap_finish", 32'(bus.finish), (i == NPIX - 1) ? 32'd1 : 32'd0);
                if (!bus.out_invalid) n_out++;
            end
        end
        chk("out_count", 32'(n_out), 32'(NOUT));
        chk("end_finish", 32'(bus.finish), 32'd1);
    endtask

    initial begin
        logic [DATA_W-1:0] wv;
        errors         = 0;
        checks         = 0;
        last_exp       = '0;
        reset          = 1'b0;
        bus.in_invalid = 1'b1;
        bus.in_data    = '0;

        do_reset();

        // contiguous positive ramp: outputs (2r+1)*24+2c+2, 26 first, 576 last
        run_ramp(1'b0, 1'b0);
        chk("last_value", bus.out_data, 32'd576);

        // extra input after finish must be ignored
        for (int i = 0; i < 50; i++) begin
            bus.in_data    = 32'(i + 7);
            bus.in_invalid = 1'b0;
            @(posedge clk);
            #1;
            chk("post_out_invalid", 32'(bus.out_invalid), 32'd1);
            chk("post_out_data", bus.out_data, 32'd576);
            chk("post_finish", 32'(bus.finish), 32'd1);
        end

        do_reset();
        run_ramp(1'b1, 1'b0);

        do_reset();
        run_ramp(1'b0, 1'b1);

        // directed extreme windows: {-5,7FFFFFFF,-7,3} and {-1,-2,-3,-4}
        do_reset();
        for (int i = 0; i < 2 * IN_W; i++) begin
            case (i)
                0:        wv = 32'hFFFF_FFFB;
                1:        wv = 32'h7FFF_FFFF;
                2:        wv = 32'hFFFF_FFFF;
                3:        wv = 32'hFFFF_FFFE;
                IN_W:     wv = 32'hFFFF_FFF9;
                IN_W + 1: wv = 32'd3;
                IN_W + 2: wv = 32'hFFFF_FFFD;
                IN_W + 3: wv = 32'hFFFF_FFFC;
                default:  wv = 32'd0;
            endcase
            bus.in_data    = wv;
            bus.in_invalid = 1'b0;
            @(posedge clk);
            #1;
            if (i == IN_W + 1) begin
                chk("win_max_invalid", 32'(bus.out_invalid), 32'd0);
                chk("win_max_data", bus.out_data, 32'h7FFF_FFFF);
            end
            if (i == IN_W + 3) begin
                chk("win_neg_invalid", 32'(bus.out_invalid), 32'd0);
                chk("win_neg_data", bus.out_data, 32'd0);
            end
        end

        // partial frame abandoned by reset, then a clean frame
        do_reset();
        for (int i = 0; i < 100; i++) begin
            bus.in_data    = 32'(i + 1);
            bus.in_invalid = 1'b0;
            @(posedge clk);
        end
        #1;
        do_reset();
        run_ramp(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
